acc_drain_unit: RTL and testbench

ACC_DRAIN_UNIT -- requirements
Module: acc_drain_unit

---
 rtl/acc_drain_unit.sv | 142 ++++++++++++++
 tb/tb_acc_drain_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain_unit.sv
// Drains a MATRIX_SIZE x MATRIX_SIZE accumulator array word by word, requantizing each word to a
// saturated DATA_WIDTH stream. Define DRAIN_RELU_EN to clamp negative results to zero.
module acc_drain_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      clear_after,
  input  logic [4:0]                shift_amt,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_in,
  output logic                      acc_rst,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StOut     = 3'd3;
  localparam logic [2:0] StClear   = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  localparam logic [ACC_ADDR_WIDTH-1:0] LastIdx =
      ACC_ADDR_WIDTH'(MATRIX_SIZE * MATRIX_SIZE - 1);
  localparam logic signed [ACC_WIDTH:0] One    = 1;
  localparam logic signed [ACC_WIDTH:0] SatMax = (2 ** (DATA_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH:0] SatMin = -(2 ** (DATA_WIDTH - 1));

  logic [2:0]                state_q, state_d;
  logic [ACC_ADDR_WIDTH-1:0] index_q, index_d;
  logic [ACC_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [4:0]                shift_q, shift_d;
  logic                      clear_q, clear_d;

  logic signed [ACC_WIDTH:0] acc_ext, rounded, shifted;
  logic [DATA_WIDTH-1:0]     quant;

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    acc_ext = {acc_in[ACC_WIDTH-1], acc_in};
    rounded = acc_ext;
    if (shift_q != 5'd0) begin
      rounded = acc_ext + (One <<< (shift_q - 5'd1));
    end
    shifted = rounded >>> shift_q;
    if (shifted > SatMax) begin
      quant = SatMax[DATA_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      quant = SatMin[DATA_WIDTH-1:0];
    end else begin
      quant = shifted[DATA_WIDTH-1:0];
    end
`ifdef DRAIN_RELU_EN
    if (quant[DATA_WIDTH-1]) begin
      quant = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    shift_d = shift_q;
    clear_d = clear_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = shift_amt;
          clear_d = clear_after;
          index_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        addr_d  = index_q;
        state_d = StCapture;
      end
      StCapture: begin
        data_d  = quant;
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (index_q == LastIdx) begin
            state_d = clear_q ? StClear : StDone;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StIssue;
          end
        end
      end
      StClear: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over a same-cycle transfer.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      index_d = index_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      shift_q <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      clear_q <= clear_d;
    end
  end

  assign addr_acc  = (state_q == StIssue) ? index_q : addr_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == StOut);
  assign out_last  = (state_q == StOut) && (index_q == LastIdx);
  assign acc_rst   = (state_q == StClear);
  assign done      = (state_q == StDone);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_acc_drain_unit.sv
// Bench for acc_drain_unit: a registered accumulator memory feeds the DUT and every transferred
// word is compared with an arithmetic requantization model.
module tb_acc_drain_unit;
  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst, start, abort, clear_after, out_ready;
  logic [4:0]  shift_amt;
  logic [5:0]  addr_acc;
  logic [31:0] acc_in;
  logic        acc_rst;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, done;

  logic [31:0] mem [N];
  logic [7:0]  last_data;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Accumulator array with one-cycle read latency.
  always @(posedge clk) acc_in <= mem[addr_acc];

  acc_drain_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .clear_after (clear_after),
    .shift_amt   (shift_amt),
    .addr_acc    (addr_acc),
    .acc_in      (acc_in),
    .acc_rst     (acc_rst),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(input logic [31:0] acc, input int sh);
    longint v;
    v = longint'($signed(acc));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
`ifdef DRAIN_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[7:0];
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind == 4 ? int'($urandom % 4) : kind)
        0:       mem[i] = $urandom;
        1:       mem[i] = 32'($signed($urandom_range(0, 600)) - 300);
        2:       mem[i] = 32'($signed($urandom_range(0, 80000)) - 40000);
        default: mem[i] = ($urandom % 2) ? 32'h7fff_ffff : 32'h8000_0000;
      endcase
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 10 cycles at word 5.
  task automatic run_drain(input int sh, input bit clr, input int mode, input int abort_at,
                           input bit poke_start);
    int k, cyc, done_cyc, rst_pulses, dones, stall, extra;
    bit prev_stall, aborted;
    logic [7:0] prev_data;
    logic [5:0] prev_addr;
    k = 0; done_cyc = 0; rst_pulses = 0; dones = 0; stall = 0; extra = 0;
    prev_stall = 0; aborted = 0; prev_data = '0; prev_addr = '0;
    start = 1'b1; shift_amt = 5'(sh); clear_after = clr; out_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0; shift_amt = 5'($urandom); clear_after = 1'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    for (cyc = 1; cyc < 2000; cyc++) begin
      if (acc_rst) rst_pulses++;
      if (done) begin dones++; done_cyc = cyc; end
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_addr", 64'(addr_acc), 64'(prev_addr));
      end
      if (done) break;
      abort = 1'b0;
      start = poke_start ? 1'($urandom) : 1'b0;
      shift_amt = 5'($urandom);
      clear_after = 1'($urandom);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        default: begin
          out_ready = !(k == 5 && stall < 10);
          if (!out_ready && out_valid) stall++;
        end
      endcase
      prev_stall = 0;
      if (out_valid) begin
        if (k == abort_at) begin
          abort = 1'b1; out_ready = 1'b1; aborted = 1;
        end else if (out_ready) begin
          check("data", 64'(out_data), 64'(ref_q(mem[k], sh)));
          check("last", 64'(out_last), 64'(k == N - 1));
          check("addr", 64'(addr_acc), 64'(k));
          last_data = out_data;
          k++;
        end else begin
          prev_stall = 1; prev_data = out_data; prev_addr = addr_acc;
        end
      end
      @(negedge clk);
      if (aborted) break;
    end
    start = 1'b0; abort = 1'b0;
    if (aborted) begin
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_count", 64'(k), 64'(abort_at));
      for (int i = 0; i < 6; i++) begin
        if (acc_rst || done || busy) extra++;
        @(negedge clk);
      end
      check("abort_quiet", 64'(extra), 64'd0);
    end else begin
      check("done_seen", 64'(dones), 64'd1);
      check("transfer_count", 64'(k), 64'(N));
      check("acc_rst_pulses", 64'(rst_pulses), 64'(clr));
      if (mode == 0) check("done_cycle", 64'(done_cyc), clr ? 64'd194 : 64'd193);
      @(negedge clk);
      check("idle_after_done", 64'({busy, done, acc_rst}), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; clear_after = 1'b0; shift_amt = '0;
    out_ready = 1'b0; last_data = '0;
    fill(1);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_acc_rst", 64'(acc_rst), 64'd0);
    check("rst_addr", 64'(addr_acc), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) mem[i] = 32'd1000;
    run_drain(3, 1, 0, -1, 0);
    check("round_1000_sh3", 64'(last_data), 64'd125);

    for (int i = 0; i < N; i++) mem[i] = 32'hffff_ec78; // -5000
    run_drain(0, 0, 0, -1, 0);
`ifdef DRAIN_RELU_EN
    check("sat_neg_relu", 64'(last_data), 64'h00);
`else
    check("sat_neg", 64'(last_data), 64'h80);
`endif

    fill(4);
    run_drain($urandom_range(0, 12), 1, 1, -1, 1);
    fill(2);
    run_drain($urandom_range(1, 10), 0, 2, -1, 0);
    fill(4);
    run_drain(5, 1, 0, 20, 0);
    fill(1);
    run_drain($urandom_range(0, 6), 1, 1, -1, 0);

    // Asynchronous reset in the middle of a drain.
    fill(4);
    start = 1'b1; shift_amt = 5'd2; clear_after = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_outs", 64'({out_last, acc_rst, done, addr_acc, out_data}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fill(0);
    run_drain($urandom_range(0, 31), 0, 0, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
